key_event_scheduler: RTL and testbench
======================================

// Module: key_event_scheduler
// PURPOSE
//  Sits behind KEY_NUM per-key debouncers and turns their one-cycle down/up pulses into
//  gesture events: SINGLE click, DOUBLE click, LONG press.
//  Runs one gesture FSM per key, round-robin arbitrates pending events into a shared FIFO,
//  and presents events to the consumer over a valid/ready interface.
// PARAMETERS
//  CLK_FREQ_MHZ  100   clock frequency; 1 ms = CLK_FREQ_MHZ*1000 cycles
//  KEY_NUM       4     number of keys, 1..16
//  LONG_MS       1000  press time in ms that qualifies as LONG
//  DCLICK_MS     300   max gap in ms between the release and the 2nd press of a DOUBLE
//  FIFO_DEPTH    8     event FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1                  clock
//  rst_n          in   1                  asynchronous active-low reset
//  key_down_pulse in   KEY_NUM            per-key debounced "pressed once" pulse
//  key_up_pulse   in   KEY_NUM            per-key debounced "released once" pulse
//  evt_valid      out  1                  FIFO head holds an event
//  evt_ready      in   1                  consumer accepts the head event
//  evt_key        out  $clog2(KEY_NUM)+1  key index of the head event
//  evt_code       out  2                  1=SINGLE 2=DOUBLE 3=LONG (0 never output)
//  fifo_count     out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  overflow       out  1                  sticky: an event was lost
//  clr_overflow   in   1                  synchronous clear of overflow
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - All FSMs go to IDLE. Timers, pendings, FIFO pointers, RR pointer and prescaler clear.
//   - All outputs are 0.
//  Timebase:
//   - A shared prescaler emits ms_tick for 1 cycle every CLK_FREQ_MHZ*1000 cycles.
//   - Each per-key timer clears on every FSM state change and increments on ms_tick.
//   - Timers saturate at LONG_MS; width is $clog2(LONG_MS+1).
//   - Timer thresholds are therefore accurate to -1 ms.
//  Per-key FSM (D = down pulse, U = up pulse; D and U in the same cycle: both ignored):
//   IDLE   : D -> PRESS1
//   PRESS1 : U -> WAIT2
//            timer==LONG_MS -> emit LONG, HOLD
//   HOLD   : U -> IDLE, no event
//   WAIT2  : D -> PRESS2
//            timer==DCLICK_MS -> emit SINGLE, IDLE
//   PRESS2 : U -> emit DOUBLE, IDLE
//            timer==LONG_MS -> emit LONG, HOLD (the first click is discarded)
//   - D in a PRESS/HOLD state, or U in IDLE/WAIT2, is ignored.
//  Emission and pending:
//   - Emitting sets a 1-deep per-key pending register {code}.
//   - An emit while pending is already set overwrites the code and sets overflow.
//   - An emit in the same cycle the pending is granted is not an overflow; the new code stays pending.
//  Arbiter:
//   - Runs each cycle when count<FIFO_DEPTH. It grants the first pending key searching upward
//     (with wrap) from last_grant+1.
//   - A grant writes {key, code} into the FIFO and clears that pending.
//   - At most 1 grant per cycle. No grant while full; there is no full-cycle pop bypass.
//  FIFO / handshake:
//   - evt_valid = (count!=0); evt_key and evt_code show the head (first-word fall-through).
//   - A pop happens when evt_valid && evt_ready. Push and pop may coincide.
//   - evt_* stay stable while evt_valid && !evt_ready.
//  Latency:
//   - An emit in cycle t shows as pending at t+1, is written to the FIFO at t+1 (if granted),
//     and gives evt_valid at t+2 when the FIFO was empty.
//  Overflow:
//   - Set on a pending overwrite. clr_overflow clears it; a set in the same cycle wins.
// TESTING (CLK_FREQ_MHZ=1, KEY_NUM=4, LONG_MS=20, DCLICK_MS=5, FIFO_DEPTH=4)
//  1 key0: D, U after 2 ms, then idle 6 ms -> exactly one event {0,SINGLE}, emitted ~5 ms after U.
//  2 key1: D, U at 2 ms, D at 3 ms, U at 4 ms -> one {1,DOUBLE}; no SINGLE emitted.
//  3 key2: D held 25 ms then U -> {2,LONG} near 20 ms; nothing emitted at U.
//  4 keys0..3 emit SINGLE in the same cycle, evt_ready=1 -> FIFO order 0,1,2,3; next batch
//    after last_grant=3 starts from key 0 again.
//  5 evt_ready=0, 4 events fill the FIFO, key0 emits twice more -> fifo_count=4, overflow=1;
//    clr_overflow clears it.
//  6 rst_n low mid-PRESS1 and with 2 FIFO entries -> evt_valid=0, fifo_count=0 immediately;
//    after release no event until a new D.

Source files
------------

// File: rtl/key_event_scheduler.sv
// Turns per-key debounced down/up pulses into SINGLE/DOUBLE/LONG events,
// arbitrated round-robin into a shared FIFO read over valid/ready.
module key_event_scheduler #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int KEY_NUM      = 4,
    parameter int LONG_MS      = 1000,
    parameter int DCLICK_MS    = 300,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [KEY_NUM-1:0]            key_down_pulse,
    input  logic [KEY_NUM-1:0]            key_up_pulse,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(KEY_NUM):0]      evt_key,
    output logic [1:0]                    evt_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int KW    = $clog2(KEY_NUM) + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TICKS = CLK_FREQ_MHZ * 1000;
    localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int TW    = $clog2(LONG_MS + 1);

    localparam logic [1:0] EV_SINGLE = 2'd1;
    localparam logic [1:0] EV_DOUBLE = 2'd2;
    localparam logic [1:0] EV_LONG   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_HOLD,
        S_WAIT2,
        S_PRESS2
    } state_t;

    // ---------------- millisecond timebase
    logic [PW-1:0] presc_q;
    logic          ms_tick;

    assign ms_tick = (presc_q == PW'(TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (ms_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // ---------------- per-key gesture FSMs
    logic [KEY_NUM-1:0] dn;
    logic [KEY_NUM-1:0] up;
    state_t             state_q   [KEY_NUM];
    state_t             state_d   [KEY_NUM];
    logic [TW-1:0]      tmr_q     [KEY_NUM];
    logic [KEY_NUM-1:0] emit;
    logic [1:0]         emit_code [KEY_NUM];

    // a simultaneous down and up on one key cancel each other
    assign dn = key_down_pulse & ~key_up_pulse;
    assign up = key_up_pulse & ~key_down_pulse;

    always_comb begin
        emit = '0;
        for (int k = 0; k < KEY_NUM; k++) begin
            state_d[k]   = state_q[k];
            emit_code[k] = 2'd0;
            unique case (state_q[k])
                S_IDLE: begin
                    if (dn[k]) state_d[k] = S_PRESS1;
                end
                S_PRESS1: begin
                    if (up[k]) begin
                        state_d[k] = S_WAIT2;
                    end else if (tmr_q[k] == TW'(LONG_MS)) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EV_LONG;
                        state_d[k]   = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (up[k]) state_d[k] = S_IDLE;
                end
                S_WAIT2: begin
                    if (dn[k]) begin
                        state_d[k] = S_PRESS2;
                    end else if (tmr_q[k] == TW'(DCLICK_MS)) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EV_SINGLE;
                        state_d[k]   = S_IDLE;
                    end
                end
                S_PRESS2: begin
                    if (up[k]) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EV_DOUBLE;
                        state_d[k]   = S_IDLE;
                    end else if (tmr_q[k] == TW'(LONG_MS)) begin
                        emit[k]      = 1'b1;
                        emit_code[k] = EV_LONG;
                        state_d[k]   = S_HOLD;
                    end
                end
                default: state_d[k] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < KEY_NUM; k++) begin
                state_q[k] <= S_IDLE;
                tmr_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                state_q[k] <= state_d[k];
                if (state_d[k] != state_q[k]) begin
                    tmr_q[k] <= '0;
                end else if (ms_tick && tmr_q[k] != TW'(LONG_MS)) begin
                    tmr_q[k] <= tmr_q[k] + 1'b1;
                end
            end
        end
    end

    // ---------------- pending registers and round-robin arbiter
    logic [KEY_NUM-1:0] pend_q;
    logic [1:0]         pend_code_q [KEY_NUM];
    logic [KW-1:0]      rr_q;
    logic [KW-1:0]      arb_cand;
    logic               gnt_vld;
    logic [KW-1:0]      gnt_idx;
    logic [1:0]         gnt_code;
    logic [KEY_NUM-1:0] gnt_oh;
    logic               full;
    logic               ovf_set;

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_code = '0;
        gnt_oh   = '0;
        arb_cand = '0;
        if (!full) begin
            for (int i = 0; i < KEY_NUM; i++) begin
                arb_cand = rr_q + KW'(i);
                if (arb_cand >= KW'(KEY_NUM)) begin
                    arb_cand = arb_cand - KW'(KEY_NUM);
                end
                for (int k = 0; k < KEY_NUM; k++) begin
                    if (!gnt_vld && pend_q[k] && arb_cand == KW'(k)) begin
                        gnt_vld   = 1'b1;
                        gnt_idx   = KW'(k);
                        gnt_code  = pend_code_q[k];
                        gnt_oh[k] = 1'b1;
                    end
                end
            end
        end
    end

    // a pending being granted this cycle may be refilled without loss
    assign ovf_set = |(emit & pend_q & ~gnt_oh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            rr_q   <= '0;
            for (int k = 0; k < KEY_NUM; k++) begin
                pend_code_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < KEY_NUM; k++) begin
                if (emit[k]) begin
                    pend_q[k]      <= 1'b1;
                    pend_code_q[k] <= emit_code[k];
                end else if (gnt_oh[k]) begin
                    pend_q[k] <= 1'b0;
                end
            end
            if (gnt_vld) begin
                rr_q <= (gnt_idx == KW'(KEY_NUM - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // ---------------- event FIFO, first-word fall-through
    logic [KW+1:0] mem [FIFO_DEPTH];
    logic [KW+1:0] head;
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [CW-1:0] cnt_q;
    logic          push;
    logic          pop;

    assign full       = (cnt_q == CW'(FIFO_DEPTH));
    assign push       = gnt_vld;
    assign pop        = evt_valid & evt_ready;
    assign evt_valid  = (cnt_q != '0);
    assign head       = mem[rp_q];
    assign evt_key    = evt_valid ? head[KW+1:2] : '0;
    assign evt_code   = evt_valid ? head[1:0] : '0;
    assign fifo_count = cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= {gnt_idx, gnt_code};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: directed gesture scenarios plus random
// pulses, every cycle compared against a gesture-level reference model.
module tb_key_event_scheduler;

    localparam int KN    = 4;
    localparam int LMS   = 20;
    localparam int DMS   = 5;
    localparam int DEPTH = 4;
    localparam int TPM   = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KN-1:0] key_down_pulse = '0;
    logic [KN-1:0] key_up_pulse = '0;
    logic          evt_valid;
    logic          evt_ready = 1'b0;
    logic [2:0]    evt_key;
    logic [1:0]    evt_code;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int log_k[$];
    int log_c[$];

    // reference model: gesture phase as (pressed, clicks, long) plus
    // timer derived from global ms-tick count since the last change
    int m_cyc, m_ticks, m_rr;
    bit m_pressed[KN];
    bit m_long[KN];
    bit m_pend[KN];
    int m_clicks[KN];
    int m_mark[KN];
    int m_pcode[KN];
    bit m_ovf;
    int q_k[$];
    int q_c[$];

    key_event_scheduler #(
        .CLK_FREQ_MHZ(1),
        .KEY_NUM(KN),
        .LONG_MS(LMS),
        .DCLICK_MS(DMS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_down_pulse(key_down_pulse),
        .key_up_pulse(key_up_pulse),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_key(evt_key),
        .evt_code(evt_code),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_ticks = 0;
        m_rr = 0;
        m_ovf = 1'b0;
        q_k.delete();
        q_c.delete();
        for (int k = 0; k < KN; k++) begin
            m_pressed[k] = 1'b0;
            m_long[k] = 1'b0;
            m_pend[k] = 1'b0;
            m_clicks[k] = 0;
            m_mark[k] = 0;
            m_pcode[k] = 0;
        end
    endtask

    task automatic model_step(input logic [KN-1:0] d, input logic [KN-1:0] u,
                              input logic rdy, input logic clr);
        int ecode[KN];
        bit chg[KN];
        bit tick;
        bit ovf_set;
        int t;
        int g;
        tick = (m_cyc % TPM) == TPM - 1;
        m_cyc++;
        for (int k = 0; k < KN; k++) begin
            bit dk;
            bit uk;
            dk = d[k] && !u[k];
            uk = u[k] && !d[k];
            t = m_ticks - m_mark[k];
            if (t > LMS) t = LMS;
            ecode[k] = 0;
            chg[k] = 1'b0;
            if (!m_pressed[k]) begin
                if (m_clicks[k] == 0) begin
                    if (dk) begin
                        m_pressed[k] = 1'b1; m_clicks[k] = 1; chg[k] = 1'b1;
                    end
                end else if (dk) begin
                    m_pressed[k] = 1'b1; m_clicks[k] = 2; chg[k] = 1'b1;
                end else if (t == DMS) begin
                    ecode[k] = 1; m_clicks[k] = 0; chg[k] = 1'b1;
                end
            end else if (m_long[k]) begin
                if (uk) begin
                    m_pressed[k] = 1'b0; m_long[k] = 1'b0; chg[k] = 1'b1;
                end
            end else if (uk) begin
                m_pressed[k] = 1'b0;
                chg[k] = 1'b1;
                if (m_clicks[k] == 2) begin
                    ecode[k] = 2; m_clicks[k] = 0;
                end
            end else if (t == LMS) begin
                ecode[k] = 3; m_long[k] = 1'b1; m_clicks[k] = 0; chg[k] = 1'b1;
            end
        end
        if (tick) m_ticks++;
        for (int k = 0; k < KN; k++) begin
            if (chg[k]) m_mark[k] = m_ticks;
        end
        g = -1;
        if (q_k.size() < DEPTH) begin
            for (int i = 0; i < KN; i++) begin
                if (g < 0 && m_pend[(m_rr + i) % KN]) g = (m_rr + i) % KN;
            end
        end
        if (q_k.size() != 0 && rdy) begin
            void'(q_k.pop_front());
            void'(q_c.pop_front());
        end
        if (g >= 0) begin
            q_k.push_back(g);
            q_c.push_back(m_pcode[g]);
            m_rr = (g + 1) % KN;
        end
        ovf_set = 1'b0;
        for (int k = 0; k < KN; k++) begin
            if (ecode[k] != 0) begin
                if (m_pend[k] && g != k) ovf_set = 1'b1;
                m_pend[k] = 1'b1;
                m_pcode[k] = ecode[k];
            end else if (g == k) begin
                m_pend[k] = 1'b0;
            end
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        int ev, ek, ec, e, g;
        ev = (q_k.size() != 0) ? 1 : 0;
        ek = ev ? q_k[0] : 0;
        ec = ev ? q_c[0] : 0;
        e = (ev << 9) | (ek << 6) | (ec << 4) | (q_k.size() << 1) | int'(m_ovf);
        g = int'({evt_valid, evt_key, evt_code, fifo_count, overflow});
        check("cycle", g, e);
    endtask

    task automatic cyc(input logic [KN-1:0] d, input logic [KN-1:0] u);
        key_down_pulse = d;
        key_up_pulse = u;
        if (evt_valid && evt_ready) begin
            log_k.push_back(int'(evt_key));
            log_c.push_back(int'(evt_code));
        end
        @(posedge clk);
        model_step(d, u, evt_ready, clr_overflow);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0);
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!evt_valid && n < maxc) begin
            cyc('0, '0);
            n++;
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    function automatic int lk(input int i);
        return (i < log_k.size()) ? log_k[i] : -1;
    endfunction

    function automatic int lc(input int i);
        return (i < log_c.size()) ? log_c[i] : -1;
    endfunction

    task automatic dbl(input logic [KN-1:0] m);
        cyc(m, '0);
        cyc('0, m);
        cyc(m, '0);
        cyc('0, m);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit mode;
        model_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_valid", int'(evt_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_key", int'({evt_key, evt_code}), 0);
        compare_all();

        // single click on key0
        evt_ready = 1'b1;
        cyc(4'b0001, '0);
        idle(2000);
        cyc('0, 4'b0001);
        wait_valid(7000, n);
        check("t1_lat_ok", int'(n >= 4000 && n <= 5010), 1);
        idle(1500);
        check("t1_n", log_k.size(), 1);
        check("t1_evt", (lk(0) << 4) | lc(0), (0 << 4) | 1);

        // double click on key1
        log_k.delete(); log_c.delete();
        cyc(4'b0010, '0);
        idle(1999);
        cyc('0, 4'b0010);
        idle(999);
        cyc(4'b0010, '0);
        idle(999);
        cyc('0, 4'b0010);
        idle(6000);
        check("t2_n", log_k.size(), 1);
        check("t2_evt", (lk(0) << 4) | lc(0), (1 << 4) | 2);

        // long press on key2
        log_k.delete(); log_c.delete();
        cyc(4'b0100, '0);
        wait_valid(21000, n);
        check("t3_lat_ok", int'(n >= 19000 && n <= 20010), 1);
        idle(25000 - n);
        cyc('0, 4'b0100);
        idle(2000);
        check("t3_n", log_k.size(), 1);
        check("t3_evt", (lk(0) << 4) | lc(0), (2 << 4) | 3);

        // simultaneous emits: round-robin order
        do_reset();
        log_k.delete(); log_c.delete();
        cyc(4'b1111, '0);
        cyc('0, 4'b1111);
        idle(6000);
        dbl(4'b1111);
        idle(20);
        check("t4_n", log_k.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t4_evt", (lk(i) << 4) | lc(i), ((i % 4) << 4) | (i < 4 ? 1 : 2));
        end

        // fill FIFO, then overflow the key0 pending
        log_k.delete(); log_c.delete();
        evt_ready = 1'b0;
        dbl(4'b1111);
        idle(6);
        dbl(4'b0001);
        dbl(4'b0001);
        idle(2);
        check("t5_count", int'(fifo_count), 4);
        check("t5_ovf", int'(overflow), 1);
        clr_overflow = 1'b1;
        cyc('0, '0);
        clr_overflow = 1'b0;
        idle(1);
        check("t5_clr", int'(overflow), 0);
        evt_ready = 1'b1;
        idle(12);
        check("t5_drain", int'(fifo_count), 0);
        check("t5_n", log_k.size(), 5);
        check("t5_last", (lk(4) << 4) | lc(4), (0 << 4) | 2);

        // async reset mid-press with entries queued
        log_k.delete(); log_c.delete();
        evt_ready = 1'b0;
        dbl(4'b0110);
        cyc(4'b0001, '0);
        idle(5);
        check("t6_pre", int'(fifo_count), 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", int'(evt_valid), 0);
        check("t6_count", int'(fifo_count), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        evt_ready = 1'b1;
        cyc('0, 4'b0001);
        idle(6000);
        check("t6_quiet", log_k.size(), 0);
        dbl(4'b0001);
        idle(5);
        check("t6_n", log_k.size(), 1);
        check("t6_evt", (lk(0) << 4) | lc(0), (0 << 4) | 2);

        // random pulses, ready bursts and occasional clears
        mode = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            logic [KN-1:0] d;
            logic [KN-1:0] u;
            if (i % 1500 == 0) mode = ($urandom_range(0, 2) != 0);
            evt_ready = mode ? 1'b1 : ($urandom_range(0, 15) == 0);
            clr_overflow = ($urandom_range(0, 255) == 0);
            for (int k = 0; k < KN; k++) begin
                d[k] = ($urandom_range(0, 299) == 0);
                u[k] = ($urandom_range(0, 299) == 0);
            end
            cyc(d, u);
        end
        clr_overflow = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
